// File: rtl/lo_mixer_bank.sv
// lo_mixer_bank: per-channel phase-accumulator LO, XOR mixer and
// accumulate-and-dump integrator with a valid/ready result port.
module lo_mixer_bank #(
  parameter  int CH      = 3,
  parameter  int PHASE_W = 16,
  parameter  int WIN_W   = 12,
  localparam int RES_W   = WIN_W + 2,
  localparam int CH_W    = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [CH-1:0]      sig,
  input  logic               fcw_wr,
  input  logic [CH_W-1:0]    fcw_ch,
  input  logic [PHASE_W-1:0] fcw_data,
  input  logic [WIN_W-1:0]   win_len,
  output logic [CH-1:0]      lo_out,
  output logic [CH-1:0]      mix_out,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [CH*RES_W-1:0] res_data,
  output logic               overrun,
  input  logic               clr_overrun
);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  localparam logic signed [RES_W-1:0] ONE = 1;

  state_t state, state_nx;

  logic [PHASE_W-1:0]      acc   [CH];
  logic [PHASE_W-1:0]      fcw   [CH];
  logic signed [RES_W-1:0] integ [CH];
  logic signed [RES_W-1:0] sum_nx [CH];
  logic [CH*RES_W-1:0]     sum_pk;

  logic [WIN_W-1:0] win_q;
  logic [WIN_W-1:0] cnt;
  logic [CH-1:0]    d;

  logic start, stop, run, dump;
  logic load, accept, ovr_set;

  always_comb begin
    lo_out = '0;
    for (int i = 0; i < CH; i++) begin
      lo_out[i] = acc[i][PHASE_W-1];
    end
  end

  assign d = sig ^ lo_out;

  always_comb begin
    state_nx = state;
    start    = 1'b0;
    stop     = 1'b0;
    unique case (state)
      IDLE: begin
        if (enable) begin
          state_nx = RUN;
          start    = 1'b1;
        end
      end
      RUN: begin
        if (!enable) begin
          state_nx = IDLE;
          stop     = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // win_q-1 wraps to all-ones for win_q==0, giving a 2^WIN_W window
  assign run  = (state == RUN) && enable;
  assign dump = run && (cnt == (win_q - WIN_W'(1)));

  always_comb begin
    sum_pk = '0;
    for (int i = 0; i < CH; i++) begin
      sum_nx[i] = d[i] ? (integ[i] - ONE) : (integ[i] + ONE);
      sum_pk[i*RES_W +: RES_W] = sum_nx[i];
    end
  end

  assign accept  = res_valid & res_ready;
  assign load    = dump & (~res_valid | res_ready);
  assign ovr_set = dump & res_valid & ~res_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mix_out <= '0;
      for (int i = 0; i < CH; i++) begin
        acc[i]   <= '0;
        fcw[i]   <= '0;
        integ[i] <= '0;
      end
    end else begin
      mix_out <= d;
      for (int i = 0; i < CH; i++) begin
        if (fcw_wr && (fcw_ch == CH_W'(i))) begin
          fcw[i] <= fcw_data;
        end
        if (state == RUN) begin
          acc[i] <= acc[i] + fcw[i];
        end
        if (start || stop || dump) begin
          integ[i] <= '0;
        end else if (run) begin
          integ[i] <= sum_nx[i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      win_q     <= '0;
      cnt       <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      overrun   <= 1'b0;
    end else begin
      state <= state_nx;
      if (start || stop || dump) begin
        cnt <= '0;
      end else if (run) begin
        cnt <= cnt + WIN_W'(1);
      end
      if (start || dump) begin
        win_q <= win_len;
      end
      if (load) begin
        res_data  <= sum_pk;
        res_valid <= 1'b1;
      end else if (accept) begin
        res_valid <= 1'b0;
      end
      if (ovr_set) begin
        overrun <= 1'b1;
      end else if (clr_overrun) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule
